// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters driving next-PC; lookup is zero-latency, updates land on the next edge.
// There is no backpressure: a held PC simply repeats the lookup while the update port keeps training.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_next_pc,
  output logic        o_pred_taken,
  output logic        o_hit,
  output logic [15:0] o_mispred_cnt
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [15:0]      mispred_cnt_q;

  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic             lkp_hit;
  logic             lkp_taken;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_pc[1:0], i_upd_pc[1:0]};

  assign lkp_idx = i_pc[IDX_W+1:2];
  assign lkp_tag = i_pc[31:IDX_W+2];
  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_tag = i_upd_pc[31:IDX_W+2];

  assign lkp_hit   = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign lkp_taken = lkp_hit && ctr_q[lkp_idx][1];
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    o_next_pc = i_pc + 32'd4;
    if (i_redirect) begin
      o_next_pc = i_redirect_pc;
    end else if (lkp_taken) begin
      o_next_pc = target_q[lkp_idx];
    end
  end

  assign o_hit         = lkp_hit;
  assign o_pred_taken  = lkp_taken;
  assign o_mispred_cnt = mispred_cnt_q;

  // Lookups see pre-edge state; a same-index update is visible only after this edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (i_upd_valid) begin
      if (upd_hit) begin
        if (i_upd_taken) begin
          target_q[upd_idx] <= i_upd_target;
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          end
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (i_upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= i_upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mispred_cnt_q <= '0;
    end else if (i_redirect) begin
      mispred_cnt_q <= mispred_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: inputs driven on the falling edge, outputs checked 1 time unit later.
module tb_branch_target_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_next_pc;
  logic        o_pred_taken;
  logic        o_hit;
  logic [15:0] o_mispred_cnt;

  branch_target_buffer #(.ENTRIES(16), .IDX_W(4)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pc          (i_pc),
    .i_upd_valid   (i_upd_valid),
    .i_upd_pc      (i_upd_pc),
    .i_upd_taken   (i_upd_taken),
    .i_upd_target  (i_upd_target),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_next_pc     (o_next_pc),
    .o_pred_taken  (o_pred_taken),
    .o_hit         (o_hit),
    .o_mispred_cnt (o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] npc;
    logic        hit;
    logic        pred;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] npc, input logic hit, input logic pred);
    exp_t e;
    e.npc  = npc;
    e.hit  = hit;
    e.pred = pred;
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check_val({t, ".next_pc"}, o_next_pc, e.npc);
    check_val({t, ".hit"}, {31'd0, o_hit}, {31'd0, e.hit});
    check_val({t, ".pred"}, {31'd0, o_pred_taken}, {31'd0, e.pred});
    check_val({t, ".cnt"}, {16'd0, o_mispred_cnt}, {16'd0, e.cnt});
  endtask

  task automatic step(input string tag, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                      input logic rd, input logic [31:0] rpc,
                      input logic [31:0] enpc, input logic eh, input logic ep);
    @(negedge i_clk);
    i_pc          = pc;
    i_upd_valid   = uv;
    i_upd_pc      = upc;
    i_upd_taken   = ut;
    i_upd_target  = utg;
    i_redirect    = rd;
    i_redirect_pc = rpc;
    expect_out(tag, enpc, eh, ep);
    #1;
    compare_out();
    if (rd) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic [31:0] enpc, input logic eh, input logic ep);
    step(tag, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, enpc, eh, ep);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc,
                     input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                     input logic [31:0] enpc, input logic eh, input logic ep);
    step(tag, pc, 1'b1, upc, ut, utg, 1'b0, 32'd0, enpc, eh, ep);
  endtask

  initial begin
    i_rst         = 1'b1;
    i_pc          = 32'h0000_0100;
    i_upd_valid   = 1'b0;
    i_upd_pc      = 32'd0;
    i_upd_taken   = 1'b0;
    i_upd_target  = 32'd0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'd0;
    #1;
    expect_out("rst", 32'h104, 1'b0, 1'b0);
    compare_out();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h300;
    #1;
    expect_out("rst_redir", 32'h300, 1'b0, 1'b0);
    compare_out();
    // Redirect held across an edge inside reset must not count.
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst      = 1'b0;
    i_redirect = 1'b0;

    upd("alloc_pre", 32'h40, 32'h40, 1'b1, 32'h200, 32'h44, 1'b0, 1'b0);
    look("alloc_hit", 32'h40, 32'h200, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      upd("sat_up", 32'h40, 32'h40, 1'b1, 32'h200, 32'h200, 1'b1, 1'b1);
    look("sat_11", 32'h40, 32'h200, 1'b1, 1'b1);
    upd("dn1", 32'h40, 32'h40, 1'b0, 32'h555, 32'h200, 1'b1, 1'b1);
    upd("dn2_tgt_kept", 32'h40, 32'h40, 1'b0, 32'h555, 32'h200, 1'b1, 1'b1);
    look("dn_nt", 32'h40, 32'h44, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      upd("sat_dn", 32'h40, 32'h40, 1'b0, 32'h555, 32'h44, 1'b1, 1'b0);
    upd("up_from_00", 32'h40, 32'h40, 1'b1, 32'h200, 32'h44, 1'b1, 1'b0);
    upd("up_from_01", 32'h40, 32'h40, 1'b1, 32'h200, 32'h44, 1'b1, 1'b0);
    look("ctr_10", 32'h40, 32'h200, 1'b1, 1'b1);

    look("alias_miss", 32'h80, 32'h84, 1'b0, 1'b0);
    upd("alias_nt", 32'h80, 32'h80, 1'b0, 32'h400, 32'h84, 1'b0, 1'b0);
    look("alias_keep", 32'h40, 32'h200, 1'b1, 1'b1);
    upd("alias_tk", 32'h40, 32'h80, 1'b1, 32'h400, 32'h200, 1'b1, 1'b1);
    look("alias_evict", 32'h40, 32'h44, 1'b0, 1'b0);
    look("alias_new", 32'h80, 32'h400, 1'b1, 1'b1);
    upd("same_idx", 32'h80, 32'h80, 1'b0, 32'h400, 32'h400, 1'b1, 1'b1);
    look("same_idx_next", 32'h80, 32'h84, 1'b1, 1'b0);

    upd("realloc", 32'h1000, 32'h40, 1'b1, 32'h200, 32'h1004, 1'b0, 1'b0);
    step("redir", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h300, 32'h300, 1'b1, 1'b1);
    look("redir_trained", 32'h40, 32'h44, 1'b1, 1'b0);
    look("pc_wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);

    @(negedge i_clk);
    i_pc          = 32'h100;
    i_upd_valid   = 1'b0;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h300;
    repeat (65534) @(negedge i_clk);
    i_redirect = 1'b0;
    exp_cnt    = exp_cnt + 16'd65534;
    step("cnt_ffff", 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h300, 32'h300, 1'b0, 1'b0);
    step("cnt_wrap0", 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h300, 32'h300, 1'b0, 1'b0);
    look("cnt_wrap1", 32'h100, 32'h104, 1'b0, 1'b0);

    // Asynchronous reset while an update is pending: entry cleared immediately, update dropped.
    @(negedge i_clk);
    i_pc         = 32'h40;
    i_upd_valid  = 1'b1;
    i_upd_pc     = 32'h40;
    i_upd_taken  = 1'b1;
    i_upd_target = 32'h700;
    i_redirect   = 1'b0;
    #2;
    i_rst   = 1'b1;
    exp_cnt = 16'd0;
    expect_out("rst_async", 32'h44, 1'b0, 1'b0);
    #1;
    compare_out();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst       = 1'b0;
    i_upd_valid = 1'b0;
    look("rst_discard", 32'h40, 32'h44, 1'b0, 1'b0);
    upd("rst_alloc", 32'h40, 32'h40, 1'b1, 32'h700, 32'h44, 1'b0, 1'b0);
    look("rst_normal", 32'h40, 32'h700, 1'b1, 1'b1);

    check_val("sb_drain", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters that produces the next-PC value for the program counter register in the pipelined CPU. Each cycle it looks up the current fetch PC and predicts taken or not-taken. A taken prediction supplies a cached target; otherwise the PC advances by 4. A resolved-branch update port from the EX stage trains the table and redirects fetch on a misprediction. The block sits directly upstream of the PC register and drives its next-PC input.

## Interface
- `ENTRIES`, 16, number of table entries; must be a power of two.
- `IDX_W`, 4, index width; equals log2(`ENTRIES`).
- `i_clk`  input  1  clock; all state updates on the rising edge.
- `i_rst`  input  1  reset; asynchronous, active-high.
- `i_pc`  input  32  current fetch PC, taken from the PC register output.
- `i_upd_valid`  input  1  a resolved branch is presented this cycle.
- `i_upd_pc`  input  32  PC of the resolved branch.
- `i_upd_taken`  input  1  actual branch direction.
- `i_upd_target`  input  32  actual branch target.
- `i_redirect`  input  1  misprediction detected in EX; fetch must restart.
- `i_redirect_pc`  input  32  correct fetch address when `i_redirect` is 1.
- `o_next_pc`  output  32  next PC, fed to the PC register input.
- `o_pred_taken`  output  1  the current lookup predicts taken; travels down the pipe with the instruction.
- `o_hit`  output  1  the current lookup hit a valid entry.
- `o_mispred_cnt`  output  16  count of redirects since reset.

## Operation
**Entry contents**
- Each entry holds `valid`, a tag, a 32-bit target and a 2-bit counter `ctr`.
- The tag is PC[31:IDX_W+2] (26 bits at the defaults).
- The index is PC[IDX_W+1:2]. PC[1:0] is ignored.

**Lookup (combinational from `i_pc` and table state)**
- hit = valid[idx] && tag[idx] == i_pc tag.
- `o_hit` = hit.
- `o_pred_taken` = hit && ctr[idx][1].
- `o_next_pc` is chosen by this priority:
  1. `i_redirect` = 1 → `i_redirect_pc`.
  2. `o_pred_taken` = 1 → target[idx].
  3. Otherwise → `i_pc` + 4, computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- `o_pred_taken` and `o_hit` reflect the table only. `i_redirect` does not force them to 0.

**Update (rising edge, when `i_upd_valid` = 1)**
- Index and tag come from `i_upd_pc`.
- **Hit, taken:** `ctr` increments, saturating at 2'b11. Target is overwritten with `i_upd_target`.
- **Hit, not taken:** `ctr` decrements, saturating at 2'b00. Target is unchanged.
- **Miss, taken:** the entry is allocated or replaced: valid = 1, tag written, target = `i_upd_target`, `ctr` = 2'b10 (weakly taken).
- **Miss, not taken:** the table is not modified.

**Misprediction counter**
- `o_mispred_cnt` increments by 1 on each rising edge where `i_redirect` = 1.
- It wraps from 0xFFFF to 0x0000.
- It is independent of `i_upd_valid`.

**Pipeline stall**
- The block has no stall input. When the PC register holds (write enable low), the lookup simply repeats on the unchanged `i_pc`, and updates proceed normally.

## Timing
**Reset (while `i_rst` = 1, asynchronous)**
- All valid = 0, all `ctr` = 2'b01, all targets = 0, all tags = 0, `o_mispred_cnt` = 0.
- Resulting outputs: `o_hit` = 0, `o_pred_taken` = 0.
- `o_next_pc` = `i_pc` + 4, or `i_redirect_pc` if `i_redirect` = 1.
- Reset asserted mid-update discards that update. The first edge after release behaves normally.

**Latency**
- The lookup has zero cycles of latency.
- An update written at edge N is visible to lookups from edge N onward, i.e. in the cycle following the one where `i_upd_valid` was asserted.

**Simultaneous lookup and update on the same index**
- The lookup uses the pre-edge table state; there is no write-through bypass.

**Simultaneous `i_redirect` and `i_upd_valid`**
- Both take effect: the table trains and the counter increments in the same edge.
- `o_next_pc` takes `i_redirect_pc` in the same cycle.

**Index aliasing**
- Two branches sharing an index evict each other only on a taken-miss allocation.

## Test plan
- **Reset:** assert `i_rst` with `i_pc` = 0x00000100 → `o_next_pc` = 0x00000104, `o_hit` = 0, `o_mispred_cnt` = 0.
- **Allocate and predict:** update `i_upd_pc` = 0x00000040, taken, target 0x00000200. Next cycle set `i_pc` = 0x00000040 → `o_hit` = 1, `o_pred_taken` = 1, `o_next_pc` = 0x00000200, `ctr` = 2'b10.
- **Counter saturation:**
  - Four taken updates to 0x40, then lookup → still taken (`ctr` 2'b11).
  - Then two not-taken updates → `o_pred_taken` = 0, `o_next_pc` = 0x00000044.
  - Then four more not-taken updates → `ctr` holds at 2'b00.
- **Tag mismatch and alias:**
  - 0x40 allocated; lookup 0x80 (same index, different tag) → `o_hit` = 0, `o_next_pc` = 0x84.
  - A not-taken update to 0x80 leaves the 0x40 entry intact.
  - A taken update to 0x80 replaces it.
- **Redirect priority and counter:** with 0x40 predicted taken, assert `i_redirect` with `i_redirect_pc` = 0x00000300 → `o_next_pc` = 0x00000300 in the same cycle. 0x10001 redirect edges → `o_mispred_cnt` = 0x0001 (wrap).
- **Same-index lookup and update, plus PC wrap:**
  - Lookup and update of 0x40 in the same cycle → the old prediction is output, and the new one appears the next cycle.
  - `i_pc` = 0xFFFFFFFC on a miss → `o_next_pc` = 0x00000000.
